// File: rtl/symbol_align_checker_if.sv
`default_nettype none
// =============================================================================
// symbol_align_checker_if : tx/rx PAM-4 symbol streams feeding the checker.
// Rev 1.0
// =============================================================================
interface symbol_align_checker_if;
  logic [1:0] tx_symbol;
  logic       tx_symbol_valid;
  logic [1:0] rx_symbol;
  logic       rx_symbol_valid;

  modport master (
    output tx_symbol, tx_symbol_valid, rx_symbol, rx_symbol_valid
  );

  modport slave (
    input tx_symbol, tx_symbol_valid, rx_symbol, rx_symbol_valid
  );
endinterface
`default_nettype wire

// File: rtl/symbol_align_checker.sv
`default_nettype none
// =============================================================================
// symbol_align_checker : PAM-4 symbol error checker with automatic latency
// search. SYMBOL_ALIGN_ERR_INJECT_EN adds i_inject_err.          Rev 1.0
// =============================================================================
module symbol_align_checker #(
  parameter  int MAX_LATENCY    = 64,
  parameter  int LOCK_WINDOW    = 64,
  parameter  int LOSS_THRESHOLD = 8,
  parameter  int CNT_WIDTH      = 32,
  localparam int LAT_W          = $clog2(MAX_LATENCY)
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire                    i_en,
`ifdef SYMBOL_ALIGN_ERR_INJECT_EN
  input  wire                    i_inject_err,
`endif
  symbol_align_checker_if.slave  sym,
  output logic                   o_locked,
  output logic [LAT_W-1:0]       o_latency,
  output logic [CNT_WIDTH-1:0]   o_total_symbols,
  output logic [CNT_WIDTH-1:0]   o_symbol_errors,
  output logic [CNT_WIDTH-1:0]   o_bit_errors,
  output logic [15:0]            o_relock_count
);

  localparam int FILL_W = $clog2(MAX_LATENCY + 1);
  localparam int WIN_W  = $clog2(LOCK_WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_hist [MAX_LATENCY];
  logic [LAT_W-1:0]     r_wr_ptr;
  logic [FILL_W-1:0]    r_fill;
  logic [LAT_W-1:0]     r_cand;
  logic [WIN_W-1:0]     r_run;
  logic [LAT_W-1:0]     r_latency;
  logic [CNT_WIDTH-1:0] r_total;
  logic [CNT_WIDTH-1:0] r_sym_err;
  logic [CNT_WIDTH-1:0] r_bit_err;
  logic [15:0]          r_relock;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [WIN_W-1:0]     r_win_err;

  logic [LAT_W-1:0]     w_cand_nxt;
  logic [WIN_W-1:0]     w_run_nxt;
  logic [LAT_W-1:0]     w_lat_nxt;
  logic [CNT_WIDTH-1:0] w_total_nxt;
  logic [CNT_WIDTH-1:0] w_sym_err_nxt;
  logic [CNT_WIDTH-1:0] w_bit_err_nxt;
  logic [15:0]          w_relock_nxt;
  logic [WIN_W-1:0]     w_win_cnt_nxt;
  logic [WIN_W-1:0]     w_win_err_nxt;

  logic                 w_tx_we;
  logic [LAT_W-1:0]     w_cand;
  logic [LAT_W-1:0]     w_rd_idx;
  logic [1:0]           w_expected;
  logic [1:0]           w_diff;
  logic [1:0]           w_bits;
  logic                 w_mis;
  logic                 w_cmp;
  logic [WIN_W-1:0]     w_run_inc;
  logic [WIN_W-1:0]     w_win_cnt_inc;
  logic [WIN_W-1:0]     w_win_err_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [1:0]           b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign w_tx_we  = i_en & sym.tx_symbol_valid;
  // While locked the compare tracks the frozen latency, otherwise the candidate.
  assign w_cand   = (r_state == S_LOCKED) ? r_latency : r_cand;
  assign w_rd_idx = r_wr_ptr - LAT_W'(1) - w_cand;

`ifdef SYMBOL_ALIGN_ERR_INJECT_EN
  assign w_expected = r_hist[w_rd_idx] ^ {1'b0, i_inject_err & (r_state == S_LOCKED)};
`else
  assign w_expected = r_hist[w_rd_idx];
`endif

  assign w_diff        = sym.rx_symbol ^ w_expected;
  assign w_bits        = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
  assign w_mis         = |w_diff;
  assign w_cmp         = i_en & sym.rx_symbol_valid & (r_state != S_IDLE)
                       & (r_fill > FILL_W'(w_cand));
  assign w_run_inc     = r_run + WIN_W'(1);
  assign w_win_cnt_inc = r_win_cnt + WIN_W'(1);
  assign w_win_err_inc = r_win_err + WIN_W'(w_mis);

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_run_nxt     = r_run;
    w_lat_nxt     = r_latency;
    w_total_nxt   = r_total;
    w_sym_err_nxt = r_sym_err;
    w_bit_err_nxt = r_bit_err;
    w_relock_nxt  = r_relock;
    w_win_cnt_nxt = r_win_cnt;
    w_win_err_nxt = r_win_err;
    if (i_en) begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SEARCH;
          w_cand_nxt  = '0;
          w_run_nxt   = '0;
        end
        S_SEARCH: begin
          if (w_cmp) begin
            if (w_mis) begin
              w_run_nxt  = '0;
              w_cand_nxt = (r_cand == LAT_W'(MAX_LATENCY - 1)) ? '0 : r_cand + LAT_W'(1);
            end else if (w_run_inc == WIN_W'(LOCK_WINDOW)) begin
              w_state_nxt   = S_LOCKED;
              w_lat_nxt     = r_cand;
              w_run_nxt     = '0;
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end
        S_LOCKED: begin
          if (w_cmp) begin
            w_total_nxt = sat_add(r_total, 2'd1);
            if (w_mis) begin
              w_sym_err_nxt = sat_add(r_sym_err, 2'd1);
              w_bit_err_nxt = sat_add(r_bit_err, w_bits);
            end
            // The error landing on the window's last compare still counts toward loss.
            if (w_mis && (w_win_err_inc >= WIN_W'(LOSS_THRESHOLD))) begin
              w_state_nxt   = S_SEARCH;
              w_cand_nxt    = '0;
              w_run_nxt     = '0;
              w_relock_nxt  = (r_relock == 16'hFFFF) ? r_relock : r_relock + 16'd1;
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end else if (w_win_cnt_inc == WIN_W'(LOCK_WINDOW)) begin
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end else begin
              w_win_cnt_nxt = w_win_cnt_inc;
              w_win_err_nxt = w_win_err_inc;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_cand    <= '0;
      r_run     <= '0;
      r_latency <= '0;
      r_total   <= '0;
      r_sym_err <= '0;
      r_bit_err <= '0;
      r_relock  <= '0;
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else begin
      if (w_tx_we) begin
        r_wr_ptr <= r_wr_ptr + LAT_W'(1);
        if (r_fill != FILL_W'(MAX_LATENCY)) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
      r_cand    <= w_cand_nxt;
      r_run     <= w_run_nxt;
      r_latency <= w_lat_nxt;
      r_total   <= w_total_nxt;
      r_sym_err <= w_sym_err_nxt;
      r_bit_err <= w_bit_err_nxt;
      r_relock  <= w_relock_nxt;
      r_win_cnt <= w_win_cnt_nxt;
      r_win_err <= w_win_err_nxt;
    end
  end

  // History contents need no reset: the fill level gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_tx_we) begin
      r_hist[r_wr_ptr] <= sym.tx_symbol;
    end
  end

  assign o_locked        = (r_state == S_LOCKED);
  assign o_latency       = r_latency;
  assign o_total_symbols = r_total;
  assign o_symbol_errors = r_sym_err;
  assign o_bit_errors    = r_bit_err;
  assign o_relock_count  = r_relock;

endmodule
`default_nettype wire

// File: tb/tb_symbol_align_checker.sv
`default_nettype none
// =============================================================================
// tb_symbol_align_checker : scoreboard bench for symbol_align_checker.  Rev 1.0
// =============================================================================
module tb_symbol_align_checker;
  localparam int WIN = 64;
  localparam int THR = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic        inj;
  logic        o_locked;
  logic [5:0]  o_latency;
  logic [31:0] o_total_symbols, o_symbol_errors, o_bit_errors;
  logic [15:0] o_relock_count;

  symbol_align_checker_if bus();

  symbol_align_checker dut (
    .clk             (clk),
    .rst             (rst),
    .i_en            (en),
`ifdef SYMBOL_ALIGN_ERR_INJECT_EN
    .i_inject_err    (inj),
`endif
    .sym             (bus),
    .o_locked        (o_locked),
    .o_latency       (o_latency),
    .o_total_symbols (o_total_symbols),
    .o_symbol_errors (o_symbol_errors),
    .o_bit_errors    (o_bit_errors),
    .o_relock_count  (o_relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic        lk;
    logic [31:0] tot, se, be;
    logic [15:0] rc;
  } exp_t;
  exp_t sb[$];

  // Tx history as sent: txh[0] is the most recent accepted tx symbol.
  // Latency L means rx equals txh[L] as seen before this cycle's tx is accepted.
  logic [1:0]  txh[$];
  int          delay;
  bit          m_locked;
  int          m_lat, m_win, m_werr;
  logic [31:0] m_tot, m_se, m_be;
  logic [15:0] m_rc;

  always @(negedge clk) begin : mon
    exp_t x;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      checks++;
      if (o_locked !== x.lk || o_total_symbols !== x.tot || o_symbol_errors !== x.se ||
          o_bit_errors !== x.be || o_relock_count !== x.rc) begin
        failures++;
        $display("FAIL scoreboard cyc=%0d actual lk=%b tot=%0d se=%0d be=%0d rc=%0d required lk=%b tot=%0d se=%0d be=%0d rc=%0d",
                 cyc, o_locked, o_total_symbols, o_symbol_errors, o_bit_errors, o_relock_count,
                 x.lk, x.tot, x.se, x.be, x.rc);
      end
    end
  end

  task automatic drive(input logic [1:0] flip, input bit en_v);
    logic [1:0] t, r, e;
    exp_t x;
    t = 2'($urandom_range(0, 3));
    r = (txh.size() > delay) ? txh[delay] : 2'($urandom_range(0, 3));
    r = r ^ flip;
    rst = 1'b0;
    en  = en_v;
    bus.tx_symbol       = t;
    bus.rx_symbol       = r;
    bus.tx_symbol_valid = en_v ? 1'b1 : 1'($urandom_range(0, 1));
    bus.rx_symbol_valid = en_v ? 1'b1 : 1'($urandom_range(0, 1));
    if (m_locked) begin
      if (en_v) begin
        e = txh[m_lat];
        m_tot++;
        if (r !== e) begin
          m_se++;
          m_be += 32'($countones(r ^ e));
          m_werr++;
        end
        if (r !== e && m_werr >= THR) begin
          m_locked = 1'b0;
          m_rc++;
        end else begin
          m_win++;
          if (m_win == WIN) begin
            m_win  = 0;
            m_werr = 0;
          end
        end
      end
      x.due = cyc + 1;
      x.lk  = m_locked;
      x.tot = m_tot;
      x.se  = m_se;
      x.be  = m_be;
      x.rc  = m_rc;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (en_v) begin
      txh.push_front(t);
      if (txh.size() > 128) void'(txh.pop_back());
    end
  endtask

  task automatic run_until_locked(input int exp_lat, output bit ok);
    int n;
    n = 0;
    while (o_locked !== 1'b1 && n < 1000) begin
      drive(2'b00, 1'b1);
      n++;
    end
    ok = (o_locked === 1'b1);
    if (ok) begin
      m_locked = 1'b1;
      m_lat    = exp_lat;
      m_win    = 0;
      m_werr   = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    bus.tx_symbol_valid = 1'b1;
    bus.rx_symbol_valid = 1'b1;
    bus.tx_symbol       = 2'($urandom_range(0, 3));
    bus.rx_symbol       = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    rst = 1'b0;
    txh.delete();
    sb.delete();
    m_locked = 1'b0;
    m_tot = '0; m_se = '0; m_be = '0; m_rc = '0;
    m_win = 0; m_werr = 0;
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%b required=0", o_locked); end
    checks++; if (o_latency !== 6'd0) begin failures++; $display("FAIL reset_latency actual=%0d required=0", o_latency); end
    checks++; if (o_total_symbols !== 32'd0) begin failures++; $display("FAIL reset_total actual=%0d required=0", o_total_symbols); end
    checks++; if (o_symbol_errors !== 32'd0) begin failures++; $display("FAIL reset_sym_err actual=%0d required=0", o_symbol_errors); end
    checks++; if (o_bit_errors !== 32'd0) begin failures++; $display("FAIL reset_bit_err actual=%0d required=0", o_bit_errors); end
    checks++; if (o_relock_count !== 16'd0) begin failures++; $display("FAIL reset_relock actual=%0d required=0", o_relock_count); end
  endtask

  task automatic test_lock;
    bit ok;
    delay = 5;
    run_until_locked(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lock_timeout actual locked=%b required=1", o_locked); end
    checks++; if (o_latency !== 6'd5) begin failures++; $display("FAIL lock_latency actual=%0d required=5", o_latency); end
    repeat (2000) drive(2'b00, 1'b1);
    checks++; if (o_total_symbols !== 32'd2000) begin failures++; $display("FAIL lock_total actual=%0d required=2000", o_total_symbols); end
    checks++; if (o_symbol_errors !== 32'd0 || o_bit_errors !== 32'd0) begin
      failures++; $display("FAIL lock_clean actual se=%0d be=%0d required se=0 be=0", o_symbol_errors, o_bit_errors);
    end
  endtask

  task automatic test_single_error;
    drive(2'b11, 1'b1);
    checks++; if (o_symbol_errors !== 32'd1) begin failures++; $display("FAIL single_sym_err actual=%0d required=1", o_symbol_errors); end
    checks++; if (o_bit_errors !== 32'd2) begin failures++; $display("FAIL single_bit_err actual=%0d required=2", o_bit_errors); end
    checks++; if (o_locked !== 1'b1) begin failures++; $display("FAIL single_locked actual=%b required=1", o_locked); end
  endtask

  task automatic test_loss;
    bit ok;
    int n;
    repeat (70) drive(2'b00, 1'b1);
    n = 0;
    while (m_win != 0 && n < WIN) begin
      drive(2'b00, 1'b1);
      n++;
    end
    repeat (THR) drive(2'b01, 1'b1);
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL loss_locked actual=%b required=0", o_locked); end
    checks++; if (o_relock_count !== 16'd1) begin failures++; $display("FAIL loss_relock actual=%0d required=1", o_relock_count); end
    checks++; if (o_symbol_errors !== 32'd9 || o_bit_errors !== 32'd10) begin
      failures++; $display("FAIL loss_counts actual se=%0d be=%0d required se=9 be=10", o_symbol_errors, o_bit_errors);
    end
    run_until_locked(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL relock_timeout actual locked=%b required=1", o_locked); end
    checks++; if (o_latency !== 6'd5) begin failures++; $display("FAIL relock_latency actual=%0d required=5", o_latency); end
    checks++; if (o_total_symbols !== m_tot || o_symbol_errors !== 32'd9 || o_bit_errors !== 32'd10) begin
      failures++; $display("FAIL relock_held actual tot=%0d se=%0d be=%0d required tot=%0d se=9 be=10",
                           o_total_symbols, o_symbol_errors, o_bit_errors, m_tot);
    end
  endtask

  task automatic test_en_hold;
    repeat (100) drive(2'($urandom_range(0, 3)), 1'b0);
    checks++; if (o_locked !== 1'b1 || o_latency !== 6'd5 || o_total_symbols !== m_tot) begin
      failures++; $display("FAIL en_hold actual lk=%b lat=%0d tot=%0d required lk=1 lat=5 tot=%0d",
                           o_locked, o_latency, o_total_symbols, m_tot);
    end
    repeat (100) drive(2'b00, 1'b1);
    checks++; if (o_total_symbols !== m_tot || o_symbol_errors !== 32'd9) begin
      failures++; $display("FAIL en_resume actual tot=%0d se=%0d required tot=%0d se=9", o_total_symbols, o_symbol_errors, m_tot);
    end
  endtask

  task automatic test_delay_change;
    bit ok;
    int n;
    delay = 5;
    run_until_locked(5, ok);
    checks++; if (!ok || o_latency !== 6'd5) begin
      failures++; $display("FAIL dc_lock5 actual lk=%b lat=%0d required lk=1 lat=5", o_locked, o_latency);
    end
    repeat (50) drive(2'b00, 1'b1);
    delay = 9;
    n = 0;
    while (m_locked && n < 300) begin
      drive(2'b00, 1'b1);
      n++;
    end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL dc_loss actual locked=%b required=0", o_locked); end
    run_until_locked(9, ok);
    checks++; if (!ok || o_latency !== 6'd9) begin
      failures++; $display("FAIL dc_lock9 actual lk=%b lat=%0d required lk=1 lat=9", o_locked, o_latency);
    end
    checks++; if (o_relock_count !== 16'd1) begin failures++; $display("FAIL dc_relock actual=%0d required=1", o_relock_count); end
    repeat (100) drive(2'b00, 1'b1);
  endtask

  initial begin
    inj      = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    delay    = 5;
    m_locked = 1'b0;
    bus.tx_symbol = 2'b00; bus.tx_symbol_valid = 1'b0;
    bus.rx_symbol = 2'b00; bus.rx_symbol_valid = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_lock;
    test_single_error;
    test_loss;
    test_en_hold;
    test_reset;
    test_delay_change;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
